// File: rtl/mem_stage_ctrl_if.sv
// Memory-stage bus: the pipeline-side operation request and results, plus
// the data-memory port driven by the controller.
interface mem_stage_ctrl_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  // pipeline request
  logic          op_valid;
  logic [2:0]    op;
  logic [AW-1:0] ea;
  logic [DW-1:0] wdata;
  logic [31:0]   pc_in;
  // data memory port
  logic [DW-1:0] MemData;
  logic [AW-1:0] Addr;
  logic [DW-1:0] DataIn;
  logic          MemeWrite;
  logic          MemeRead;
  // results towards the pipeline
  logic          stall;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic [31:0]   pc_out;
  logic          pc_valid;
  logic [AW-1:0] sp;
  logic          stack_err;

  // upstream pipeline and memory side
  modport master (
    output op_valid, op, ea, wdata, pc_in, MemData,
    input  Addr, DataIn, MemeWrite, MemeRead, stall,
    input  rdata, rdata_valid, pc_out, pc_valid, sp, stack_err
  );

  // the memory-stage controller
  modport slave (
    input  op_valid, op, ea, wdata, pc_in, MemData,
    output Addr, DataIn, MemeWrite, MemeRead, stall,
    output rdata, rdata_valid, pc_out, pc_valid, sp, stack_err
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data memory for loads, stores,
// push/pop and the two-word CALL/RET program-counter transfers, and owns
// the downward-growing stack pointer.
module mem_stage_ctrl #(
  parameter int            AW      = 11,
  parameter int            DW      = 16,
  parameter logic [AW-1:0] SP_INIT = 11'h7FF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  mem_stage_ctrl_if.slave      bus
);

  localparam logic [2:0] OP_LDD  = 3'b001;
  localparam logic [2:0] OP_STD  = 3'b010;
  localparam logic [2:0] OP_PUSH = 3'b011;
  localparam logic [2:0] OP_POP  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALL2 = 2'd1,
    ST_RET2  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_sp;
  logic [AW-1:0] w_sp_next;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] w_lo_next;
  logic [DW-1:0] r_rdata;
  logic          r_rdata_valid;
  logic [31:0]   r_pc_out;
  logic          r_pc_valid;
  logic          r_stack_err;

  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_din;
  logic          w_wr;
  logic          w_rd;
  logic          w_stall;
  logic          w_err_set;
  logic          w_rdata_load;
  logic          w_pc_load;

  // Stack steps wrap modulo 2^AW; the edge compares flag the wrap.
  logic [AW-1:0] w_sp_inc;
  logic [AW-1:0] w_sp_dec;
  logic          w_sp_max;
  logic          w_sp_zero;
  assign w_sp_inc  = r_sp + {{(AW-1){1'b0}}, 1'b1};
  assign w_sp_dec  = r_sp - {{(AW-1){1'b0}}, 1'b1};
  assign w_sp_max  = (r_sp == {AW{1'b1}});
  assign w_sp_zero = (r_sp == {AW{1'b0}});

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, memory strobes and datapath controls; all quiet during reset.
  always_comb begin
    w_state_next = r_state;
    w_addr       = {AW{1'b0}};
    w_din        = {DW{1'b0}};
    w_wr         = 1'b0;
    w_rd         = 1'b0;
    w_stall      = 1'b0;
    w_sp_next    = r_sp;
    w_lo_next    = r_lo;
    w_err_set    = 1'b0;
    w_rdata_load = 1'b0;
    w_pc_load    = 1'b0;
    if (Rst) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op)
              OP_LDD: begin
                w_addr       = bus.ea;
                w_rd         = 1'b1;
                w_rdata_load = 1'b1;
              end
              OP_STD: begin
                w_addr = bus.ea;
                w_din  = bus.wdata;
                w_wr   = 1'b1;
              end
              OP_PUSH: begin
                w_addr    = r_sp;
                w_din     = bus.wdata;
                w_wr      = 1'b1;
                w_sp_next = w_sp_dec;
                w_err_set = w_sp_zero;
              end
              OP_POP: begin
                w_addr       = w_sp_inc;
                w_rd         = 1'b1;
                w_rdata_load = 1'b1;
                w_sp_next    = w_sp_inc;
                w_err_set    = w_sp_max;
              end
              OP_CALL: begin
                // high half first so the low half ends at the lower address
                w_addr       = r_sp;
                w_din        = bus.pc_in[31:16];
                w_wr         = 1'b1;
                w_stall      = 1'b1;
                w_lo_next    = bus.pc_in[15:0];
                w_sp_next    = w_sp_dec;
                w_err_set    = w_sp_zero;
                w_state_next = ST_CALL2;
              end
              OP_RET: begin
                w_addr       = w_sp_inc;
                w_rd         = 1'b1;
                w_stall      = 1'b1;
                w_lo_next    = bus.MemData;
                w_sp_next    = w_sp_inc;
                w_err_set    = w_sp_max;
                w_state_next = ST_RET2;
              end
              default: begin
                w_state_next = ST_IDLE;
              end
            endcase
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_CALL2: begin
          w_addr       = r_sp;
          w_din        = r_lo;
          w_wr         = 1'b1;
          w_sp_next    = w_sp_dec;
          w_err_set    = w_sp_zero;
          w_state_next = ST_IDLE;
        end
        ST_RET2: begin
          w_addr       = w_sp_inc;
          w_rd         = 1'b1;
          w_pc_load    = 1'b1;
          w_sp_next    = w_sp_inc;
          w_err_set    = w_sp_max;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Stack pointer, latched half-word, results and sticky stack error.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sp          <= SP_INIT;
      r_lo          <= {DW{1'b0}};
      r_rdata       <= {DW{1'b0}};
      r_rdata_valid <= 1'b0;
      r_pc_out      <= 32'h0000_0000;
      r_pc_valid    <= 1'b0;
      r_stack_err   <= 1'b0;
    end else begin
      r_sp          <= w_sp_next;
      r_lo          <= w_lo_next;
      r_rdata_valid <= w_rdata_load;
      r_pc_valid    <= w_pc_load;
      if (w_rdata_load) begin
        r_rdata <= bus.MemData;
      end
      if (w_pc_load) begin
        r_pc_out <= {bus.MemData, r_lo};
      end
      if (w_err_set) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  assign bus.Addr        = w_addr;
  assign bus.DataIn      = w_din;
  assign bus.MemeWrite   = w_wr;
  assign bus.MemeRead    = w_rd;
  assign bus.stall       = w_stall;
  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.pc_out      = r_pc_out;
  assign bus.pc_valid    = r_pc_valid;
  assign bus.sp          = r_sp;
  assign bus.stack_err   = r_stack_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a 2048x16 memory model writing on the falling
// edge, directed operations, and result queues checked when pulses appear.
module tb_mem_stage_ctrl;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LDD  = 3'b001;
  localparam logic [2:0] STD  = 3'b010;
  localparam logic [2:0] PUSH = 3'b011;
  localparam logic [2:0] POP  = 3'b100;
  localparam logic [2:0] CALL = 3'b101;
  localparam logic [2:0] RET  = 3'b110;
  localparam logic [2:0] RSV  = 3'b111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [15:0] mem [0:2047];
  logic [15:0] rq [$];
  logic [31:0] pq [$];

  mem_stage_ctrl_if #(.AW(11), .DW(16)) bus ();

  mem_stage_ctrl #(.AW(11), .DW(16), .SP_INIT(11'h7FF)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // data memory model: combinational read, falling-edge write
  assign bus.MemData = mem[bus.Addr];
  always @(negedge clk) begin
    if (bus.MemeWrite === 1'b1) begin
      mem[bus.Addr] <= bus.DataIn;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // result monitor: pops expected values when a pulse is seen
  always @(negedge clk) begin
    if (bus.rdata_valid === 1'b1) begin
      if (rq.size() == 0) begin
        check_eq("rdata_spurious", {31'd0, bus.rdata_valid}, 32'd0);
      end else begin
        check_eq("rdata", {16'd0, bus.rdata}, {16'd0, rq.pop_front()});
      end
    end
    if (bus.pc_valid === 1'b1) begin
      if (pq.size() == 0) begin
        check_eq("pc_spurious", {31'd0, bus.pc_valid}, 32'd0);
      end else begin
        check_eq("pc_out", bus.pc_out, pq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [2:0] o, input logic [10:0] a,
                        input logic [15:0] d, input logic [31:0] p);
    bus.op_valid = v;
    bus.op       = o;
    bus.ea       = a;
    bus.wdata    = d;
    bus.pc_in    = p;
    #2;
  endtask

  task automatic exp_mem(input string t, input logic [10:0] a, input logic [15:0] d,
                         input logic wr, input logic rd, input logic st);
    check_eq({t, ".addr"},  {21'd0, bus.Addr},      {21'd0, a});
    check_eq({t, ".din"},   {16'd0, bus.DataIn},    {16'd0, d});
    check_eq({t, ".wr"},    {31'd0, bus.MemeWrite}, {31'd0, wr});
    check_eq({t, ".rd"},    {31'd0, bus.MemeRead},  {31'd0, rd});
    check_eq({t, ".stall"}, {31'd0, bus.stall},     {31'd0, st});
  endtask

  task automatic exp_sp(input string t, input logic [10:0] s);
    check_eq(t, {21'd0, bus.sp}, {21'd0, s});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_op(1'b1, CALL, 11'h000, 16'h0000, 32'hFFFF_FFFF);
    exp_mem("rst_quiet", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    exp_sp("rst_sp", 11'h7FF);
    check_eq("rst_rdata", {16'd0, bus.rdata}, 32'd0);
    check_eq("rst_pc", bus.pc_out, 32'd0);
    check_eq("rst_err", {31'd0, bus.stack_err}, 32'd0);
    exp_mem("idle", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    // store then load
    set_op(1'b1, STD, 11'h010, 16'hBEEF, 32'h0);
    exp_mem("std", 11'h010, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    set_op(1'b1, LDD, 11'h010, 16'h0000, 32'h0);
    rq.push_back(16'hBEEF);
    exp_mem("ldd", 11'h010, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    set_op(1'b0, LDD, 11'h010, 16'h0000, 32'h0);
    check_eq("ldd_valid", {31'd0, bus.rdata_valid}, 32'd1);
    exp_mem("opv0", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("ldd_pulse_end", {31'd0, bus.rdata_valid}, 32'd0);

    // push / pop
    set_op(1'b1, PUSH, 11'h000, 16'h1111, 32'h0);
    exp_mem("push1", 11'h7FF, 16'h1111, 1'b1, 1'b0, 1'b0);
    tick();
    exp_sp("sp_push1", 11'h7FE);
    set_op(1'b1, PUSH, 11'h000, 16'h2222, 32'h0);
    exp_mem("push2", 11'h7FE, 16'h2222, 1'b1, 1'b0, 1'b0);
    tick();
    exp_sp("sp_push2", 11'h7FD);
    check_eq("mem7FF", {16'd0, mem[11'h7FF]}, 32'h1111);
    check_eq("mem7FE", {16'd0, mem[11'h7FE]}, 32'h2222);
    set_op(1'b1, POP, 11'h000, 16'h0000, 32'h0);
    rq.push_back(16'h2222);
    exp_mem("pop1", 11'h7FE, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    exp_sp("sp_pop1", 11'h7FE);
    set_op(1'b1, POP, 11'h000, 16'h0000, 32'h0);
    rq.push_back(16'h1111);
    exp_mem("pop2", 11'h7FF, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    exp_sp("sp_pop2", 11'h7FF);

    // CALL then RET, with garbage op while the second access runs
    set_op(1'b1, CALL, 11'h000, 16'h0000, 32'h0001_0A5C);
    exp_mem("call1", 11'h7FF, 16'h0001, 1'b1, 1'b0, 1'b1);
    tick();
    set_op(1'b1, RSV, 11'h123, 16'hDEAD, 32'hFFFF_FFFF);
    exp_mem("call2", 11'h7FE, 16'h0A5C, 1'b1, 1'b0, 1'b0);
    tick();
    exp_sp("sp_call", 11'h7FD);
    set_op(1'b1, RET, 11'h000, 16'h0000, 32'h0);
    pq.push_back(32'h0001_0A5C);
    exp_mem("ret1", 11'h7FE, 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    set_op(1'b1, STD, 11'h555, 16'hDEAD, 32'h0);
    exp_mem("ret2", 11'h7FF, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    exp_sp("sp_ret", 11'h7FF);
    check_eq("ret_pv", {31'd0, bus.pc_valid}, 32'd1);
    check_eq("call_hi", {16'd0, mem[11'h7FF]}, 32'h0001);
    check_eq("call_lo", {16'd0, mem[11'h7FE]}, 32'h0A5C);

    // reserved op does nothing
    set_op(1'b1, RSV, 11'h0AA, 16'h1234, 32'h0);
    exp_mem("rsv", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    exp_sp("sp_rsv", 11'h7FF);
    check_eq("pv_end", {31'd0, bus.pc_valid}, 32'd0);

    // reset during CALL2 suppresses the second write
    set_op(1'b1, CALL, 11'h000, 16'h0000, 32'h1234_5678);
    tick();
    rst = 1'b1;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    exp_mem("call2_rst", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    exp_sp("sp_call_abort", 11'h7FF);
    check_eq("abort_7FE", {16'd0, mem[11'h7FE]}, 32'h0A5C);
    check_eq("abort_7FF", {16'd0, mem[11'h7FF]}, 32'h1234);
    exp_mem("after_abort", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    // reset during RET2 suppresses the read and the pc pulse
    set_op(1'b1, PUSH, 11'h000, 16'hAAAA, 32'h0);
    tick();
    set_op(1'b1, PUSH, 11'h000, 16'hBBBB, 32'h0);
    tick();
    set_op(1'b1, RET, 11'h000, 16'h0000, 32'h0);
    tick();
    rst = 1'b1;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    exp_mem("ret2_rst", 11'h000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    exp_sp("sp_ret_abort", 11'h7FF);
    check_eq("ret_abort_pv", {31'd0, bus.pc_valid}, 32'd0);
    tick();

    // POP at the top wraps and sets the sticky error
    set_op(1'b1, STD, 11'h000, 16'h5A5A, 32'h0);
    tick();
    set_op(1'b1, POP, 11'h000, 16'h0000, 32'h0);
    rq.push_back(16'h5A5A);
    exp_mem("pop_wrap", 11'h000, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    exp_sp("sp_wrap", 11'h000);
    check_eq("err_set", {31'd0, bus.stack_err}, 32'd1);
    set_op(1'b1, LDD, 11'h010, 16'h0000, 32'h0);
    rq.push_back(16'hBEEF);
    tick();
    set_op(1'b1, PUSH, 11'h000, 16'h7777, 32'h0);
    exp_mem("push_at0", 11'h000, 16'h7777, 1'b1, 1'b0, 1'b0);
    tick();
    exp_sp("sp_unwrap", 11'h7FF);
    check_eq("err_sticky", {31'd0, bus.stack_err}, 32'd1);
    rst = 1'b1;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    tick();
    rst = 1'b0;
    set_op(1'b0, NOP, 11'h000, 16'h0000, 32'h0);
    check_eq("err_cleared", {31'd0, bus.stack_err}, 32'd0);
    tick();
    tick();

    check_eq("rq_left", rq.size(), 32'd0);
    check_eq("pq_left", pq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
